uart_rx_frame: RTL



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sync.sv | 33 +++
 rtl/uart_rx_frame.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int unsigned WORD_LENGTH_DEFAULT = 8;
  localparam int unsigned FRAME_BITS          = WORD_LENGTH_DEFAULT + 3;

endpackage

// File: rtl/uart_rx_sync.sv
// Serial line input conditioning: 2-flop synchroniser plus a delay flop for
// falling-edge (start) detection. All flops reset to the idle level.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic serial_i,
  output logic line_sync,
  output logic start_edge
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= IDLE_LEVEL;
      sync_q <= IDLE_LEVEL;
      dly_q  <= IDLE_LEVEL;
    end else begin
      meta_q <= serial_i;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign line_sync  = sync_q;
  // A held-low line (break) never re-triggers: a fresh 1->0 transition is needed.
  assign start_edge = (sync_q == START_BIT) && (dly_q == IDLE_LEVEL);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start, WORD_LENGTH data bits LSB-first, even parity, stop.
// Define UART_RX_PARITY_CHECK_EN to build the parity checker; otherwise
// parity_error is tied 0 (the parity bit is still timed).
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int unsigned WORD_LENGTH  = 8,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   SerialDataIn,
  output logic [WORD_LENGTH-1:0] DataRX,
  output logic                   rx_valid,
  output logic                   parity_error,
  output logic                   framing_error,
  output logic                   busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(WORD_LENGTH + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_LENGTH - 1);

  logic line_sync;
  logic start_edge;

  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   ferr_q, ferr_d;
  logic                   valid_q, valid_d;
  logic                   tick_last;
`ifdef UART_RX_PARITY_CHECK_EN
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .clk        (clk),
    .rst_n      (reset),
    .serial_i   (SerialDataIn),
    .line_sync  (line_sync),
    .start_edge (start_edge)
  );

  assign tick_last = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
`ifdef UART_RX_PARITY_CHECK_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_edge) state_d = START;
      end
      START: begin
        idx_d = '0;
        if (cnt_q == CNT_HALF) begin
          state_d = (line_sync == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (tick_last) begin
          shift_d = {line_sync, shift_q[WORD_LENGTH-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_LAST) state_d = PARITY;
        end
      end
      PARITY: begin
        if (tick_last) begin
`ifdef UART_RX_PARITY_CHECK_EN
          par_d = line_sync;
`endif
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick_last) begin
          data_d  = shift_q;
`ifdef UART_RX_PARITY_CHECK_EN
          perr_d  = par_q ^ (^shift_q);
`endif
          ferr_d  = (line_sync != STOP_BIT);
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Timer restarts on every state change so each state measures from its own entry.
    if ((state_d != state_q) || (state_q == IDLE) || tick_last) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
    end
  end

`ifdef UART_RX_PARITY_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end

  assign parity_error = perr_q;
`else
  assign parity_error = 1'b0;
`endif

  assign DataRX        = data_q;
  assign rx_valid      = valid_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != IDLE);

endmodule
